// File: rtl/uart_rx_frame_parser.sv
// UART byte-stream frame parser: header/cmd/len/payload/checksum, payload buffered for a held frame.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_parser #(
  parameter int         MAX_LEN     = 64,
  parameter int         AW          = 6,
  parameter logic [7:0] HDR0        = 8'h55,
  parameter logic [7:0] HDR1        = 8'hAA,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_done_i,
  output logic          frame_valid_o,
  output logic [7:0]    frame_cmd_o,
  output logic [7:0]    frame_len_o,
  input  logic          frame_ack_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [7:0]    drop_cnt_o
);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [16:0] TMO_LAST  = 17'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_H0, S_H1, S_CMD, S_LEN, S_PAY, S_CSUM, S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0, ERR_LEN = 2'd1, ERR_CSUM = 2'd2, ERR_TMO = 2'd3
  } err_t;

  state_t      state;
  logic [7:0]  cmd_q;
  logic [7:0]  len_q;
  logic [7:0]  csum;
  logic [7:0]  idx;
  logic [16:0] tmo_cnt;
  logic        timed;
  logic        tmo_hit;
  logic        wr_en;

  logic [7:0]  mem [2**AW];

  // NOTE: always_comb outputs are assigned on every path so no latch is inferred.
  always_comb begin
    timed   = 1'b0;
    timed   = state inside {S_H1, S_CMD, S_LEN, S_PAY, S_CSUM};
    tmo_hit = TMO_EN && timed && !rx_done_i && (tmo_cnt == TMO_LAST);
    wr_en   = rx_done_i && (state == S_PAY);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= S_H0;
      cmd_q         <= 8'd0;
      len_q         <= 8'd0;
      csum          <= 8'd0;
      idx           <= 8'd0;
      tmo_cnt       <= 17'd0;
      frame_valid_o <= 1'b0;
      frame_cmd_o   <= 8'd0;
      frame_len_o   <= 8'd0;
      err_o         <= 1'b0;
      err_code_o    <= ERR_NONE;
      drop_cnt_o    <= 8'd0;
    end else begin
      err_o <= 1'b0;

      // Counter runs only while waiting for a byte inside a frame; any byte or expiry clears it.
      if (TMO_EN && timed && !rx_done_i && !tmo_hit) tmo_cnt <= tmo_cnt + 17'd1;
      else                                           tmo_cnt <= 17'd0;

      if (tmo_hit) begin
        err_o      <= 1'b1;
        err_code_o <= ERR_TMO;
        state      <= S_H0;
      end else begin
        unique case (state)
          S_H0: if (rx_done_i && rx_data_i == HDR0) state <= S_H1;

          S_H1: if (rx_done_i) begin
            if (rx_data_i == HDR1)      state <= S_CMD;
            else if (rx_data_i != HDR0) state <= S_H0;
          end

          S_CMD: if (rx_done_i) begin
            cmd_q <= rx_data_i;
            csum  <= rx_data_i;
            state <= S_LEN;
          end

          S_LEN: if (rx_done_i) begin
            len_q <= rx_data_i;
            csum  <= csum + rx_data_i;
            idx   <= 8'd0;
            if (rx_data_i > MAX_LEN_B) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_LEN;
              state      <= S_H0;
            end else if (rx_data_i == 8'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_PAY;
            end
          end

          S_PAY: if (rx_done_i) begin
            csum <= csum + rx_data_i;
            idx  <= idx + 8'd1;
            if (idx == len_q - 8'd1) state <= S_CSUM;
          end

          S_CSUM: if (rx_done_i) begin
            if (rx_data_i == csum) begin
              frame_valid_o <= 1'b1;
              frame_cmd_o   <= cmd_q;
              frame_len_o   <= len_q;
              state         <= S_HOLD;
            end else begin
              err_o      <= 1'b1;
              err_code_o <= ERR_CSUM;
              state      <= S_H0;
            end
          end

          S_HOLD: begin
            if (rx_done_i && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
            if (frame_ack_i) begin
              frame_valid_o <= 1'b0;
              state         <= S_H0;
            end
          end

          default: state <= S_H0;
        endcase
      end
    end
  end

  // NOTE: the payload RAM has no reset; its contents are meaningful only for a held frame.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[idx[AW-1:0]] <= rx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rd_data_o <= 8'd0;
    else          rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed, scoreboard-driven bench for uart_rx_frame_parser (timeout section under UART_FRAME_TIMEOUT_EN).
module tb_uart_rx_frame_parser;

  localparam int AW  = 6;
  localparam int TMO = 2000;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [7:0]    rx_data_i;
  logic          rx_done_i;
  logic          frame_valid_o;
  logic [7:0]    frame_cmd_o;
  logic [7:0]    frame_len_o;
  logic          frame_ack_i;
  logic [AW-1:0] rd_addr_i;
  logic [7:0]    rd_data_o;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic [7:0]    drop_cnt_o;

  uart_rx_frame_parser #(.MAX_LEN(64), .AW(AW), .HDR0(8'h55), .HDR1(8'hAA), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
    .frame_valid_o(frame_valid_o), .frame_cmd_o(frame_cmd_o), .frame_len_o(frame_len_o),
    .frame_ack_i(frame_ack_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .err_o(err_o), .err_code_o(err_code_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] seed;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   err_pulses = 0;

  always @(negedge clk_i) if (err_o) err_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_i); #1;
    rx_data_i = b;
    rx_done_i = 1'b1;
    @(posedge clk_i); #1;
    rx_done_i = 1'b0;
  endtask

  // Payload byte i is seed+i; checksum is the 8-bit sum of cmd, len and payload.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input logic [7:0] seed, input bit bad);
    exp_t       e;
    logic [7:0] cs;
    e.is_err = bad; e.code = bad ? 2'd2 : 2'd0; e.cmd = cmd; e.len = len; e.seed = seed;
    sb.push_back(e);
    cs = cmd + len;
    send_byte(8'h55); send_byte(8'hAA); send_byte(cmd); send_byte(len);
    for (int i = 0; i < int'(len); i++) begin
      send_byte(seed + 8'(i));
      cs = cs + seed + 8'(i);
    end
    send_byte(bad ? cs - 8'd1 : cs);
  endtask

  task automatic read_payload(input string tag, input logic [7:0] len, input logic [7:0] seed);
    for (int i = 0; i < int'(len); i++) begin
      @(posedge clk_i); #1;
      rd_addr_i = AW'(i);
      @(posedge clk_i); #1;
      check($sformatf("%s_rd%0d", tag, i), rd_data_o, seed + 8'(i));
    end
  endtask

  task automatic expect_result(input string tag, input int max_cyc);
    exp_t e;
    int   start;
    bit   got;
    e     = sb.pop_front();
    start = err_pulses;
    got   = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk_i);
      if (frame_valid_o || err_pulses != start) got = 1'b1;
    end
    check({tag, "_seen"}, got, 1'b1);
    if (e.is_err) begin
      repeat (3) @(negedge clk_i);
      check({tag, "_err_pulses"}, err_pulses - start, 1);
      check({tag, "_err_code"}, err_code_o, e.code);
      check({tag, "_no_valid"}, frame_valid_o, 1'b0);
    end else begin
      check({tag, "_valid"}, frame_valid_o, 1'b1);
      check({tag, "_cmd"}, frame_cmd_o, e.cmd);
      check({tag, "_len"}, frame_len_o, e.len);
      check({tag, "_no_err"}, err_pulses, start);
      read_payload(tag, e.len, e.seed);
    end
  endtask

  task automatic ack_frame(input string tag);
    @(posedge clk_i); #1;
    frame_ack_i = 1'b1;
    @(posedge clk_i); #1;
    frame_ack_i = 1'b0;
    check({tag, "_ack_drop"}, frame_valid_o, 1'b0);
  endtask

  int start_pulses;

  initial begin
    rst_n_i = 1'b0; rx_data_i = 8'd0; rx_done_i = 1'b0; frame_ack_i = 1'b0; rd_addr_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", frame_valid_o, 1'b0);
    check("rst_cmd", frame_cmd_o, 8'd0);
    check("rst_len", frame_len_o, 8'd0);
    check("rst_err", err_o, 1'b0);
    check("rst_code", err_code_o, 2'd0);
    check("rst_drop", drop_cnt_o, 8'd0);
    check("rst_rd", rd_data_o, 8'd0);
    @(negedge clk_i); rst_n_i = 1'b1;

    // 55 AA 10 03 01 02 03 19
    send_frame(8'h10, 8'd3, 8'h01, 1'b0);
    expect_result("good1", 20);
    ack_frame("good1");

    // Same frame with checksum 18, then a correct one.
    send_frame(8'h10, 8'd3, 8'h01, 1'b1);
    expect_result("bad_csum", 20);
    send_frame(8'h10, 8'd3, 8'h01, 1'b0);
    expect_result("after_bad", 20);
    ack_frame("after_bad");

    // Oversized length, then a repeated HDR0 before a zero-length frame.
    sb.push_back('{is_err: 1'b1, code: 2'd1, cmd: 8'h20, len: 8'h41, seed: 8'h00});
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h20); send_byte(8'h41);
    expect_result("len_err", 20);
    send_byte(8'h55);
    send_frame(8'h07, 8'd0, 8'h00, 1'b0);
    expect_result("len0", 20);
    ack_frame("len0");

    // Full-length frame held while 300 bytes stream in without an ack.
    send_frame(8'h5A, 8'd64, 8'hC0, 1'b0);
    expect_result("maxlen", 20);
    start_pulses = err_pulses;
    for (int i = 0; i < 300; i++) send_byte(8'(i));
    @(negedge clk_i);
    check("drop_sat", drop_cnt_o, 8'd255);
    check("drop_valid", frame_valid_o, 1'b1);
    check("drop_cmd", frame_cmd_o, 8'h5A);
    check("drop_len", frame_len_o, 8'd64);
    check("drop_no_err", err_pulses, start_pulses);
    read_payload("drop", 8'd64, 8'hC0);
    ack_frame("maxlen");

`ifdef UART_FRAME_TIMEOUT_EN
    // A byte on the expiry cycle wins; afterwards a full idle window times out.
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h10);
    start_pulses = err_pulses;
    repeat (TMO - 2) @(posedge clk_i);
    send_byte(8'h00);
    @(negedge clk_i);
    check("tmo_boundary_no_err", err_pulses, start_pulses);
    sb.push_back('{is_err: 1'b1, code: 2'd3, cmd: 8'h10, len: 8'h00, seed: 8'h00});
    expect_result("timeout", TMO + 20);
`endif

    // Reset in the middle of a 10-byte payload.
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h30); send_byte(8'd10);
    for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i));
    rst_n_i = 1'b0;
    #1;
    check("midrst_valid", frame_valid_o, 1'b0);
    check("midrst_cmd", frame_cmd_o, 8'd0);
    check("midrst_code", err_code_o, 2'd0);
    check("midrst_drop", drop_cnt_o, 8'd0);
    check("midrst_rd", rd_data_o, 8'd0);
    @(negedge clk_i); rst_n_i = 1'b1;
    send_frame(8'h33, 8'd10, 8'h80, 1'b0);
    expect_result("post_rst", 20);
    ack_frame("post_rst");

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
